// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit : single-outstanding instruction fetch feeding a 2-entry queue
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       ADDRESS_WIDTH = 16,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     instr_valid,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  input  logic                     instr_ready
);

  typedef enum logic [1:0] {
    S_ISSUE   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  localparam logic [ADDRESS_WIDTH-1:0] c_pc_step = ADDRESS_WIDTH'(4);

  state_e                   state_q,     state_d;
  logic [ADDRESS_WIDTH-1:0] fetch_pc_q,  fetch_pc_d;
  logic [ADDRESS_WIDTH-1:0] out_pc_q,    out_pc_d;
  logic                     req_en_q,    req_en_d;
  logic [1:0]               count_q,     count_d;
  logic [DATA_WIDTH-1:0]    head_data_q, head_data_d;
  logic [ADDRESS_WIDTH-1:0] head_pc_q,   head_pc_d;
  logic [DATA_WIDTH-1:0]    tail_data_q, tail_data_d;
  logic [ADDRESS_WIDTH-1:0] tail_pc_q,   tail_pc_d;

  logic grant;
  logic pop;
  logic push;
  logic unused_redirect_lsbs;

  // req_en_q is registered so the first request appears one edge after reset release
  assign imem_req    = req_en_q & ~redirect_valid;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (count_q != 2'd0);
  assign instr       = head_data_q;
  assign instr_pc    = head_pc_q;

  assign grant = imem_req & imem_gnt;
  assign pop   = instr_valid & instr_ready & ~redirect_valid;
  assign push  = (state_q == S_WAIT) & imem_rvalid & ~redirect_valid;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    out_pc_d    = out_pc_q;
    count_d     = count_q;
    head_data_d = head_data_q;
    head_pc_d   = head_pc_q;
    tail_data_d = tail_data_q;
    tail_pc_d   = tail_pc_q;

    unique case (state_q)
      S_ISSUE: begin
        if (grant) begin
          state_d    = S_WAIT;
          out_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + c_pc_step;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_ISSUE;
        end else if (redirect_valid) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_rvalid) begin
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_ISSUE;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
      count_d    = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_data_d = imem_rdata;
            head_pc_d   = out_pc_q;
            count_d     = 2'd1;
          end else if (count_q == 2'd1) begin
            tail_data_d = imem_rdata;
            tail_pc_d   = out_pc_q;
            count_d     = 2'd2;
          end
        end
        2'b01: begin
          head_data_d = tail_data_q;
          head_pc_d   = tail_pc_q;
          count_d     = count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; with a single entry the new word becomes head
          if (count_q == 2'd1) begin
            head_data_d = imem_rdata;
            head_pc_d   = out_pc_q;
          end else begin
            head_data_d = tail_data_q;
            head_pc_d   = tail_pc_q;
            tail_data_d = imem_rdata;
            tail_pc_d   = out_pc_q;
          end
        end
        default: ;
      endcase
    end

    req_en_d = (state_d == S_ISSUE) && (count_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_ISSUE;
      fetch_pc_q  <= RESET_PC;
      out_pc_q    <= '0;
      req_en_q    <= 1'b0;
      count_q     <= 2'd0;
      head_data_q <= '0;
      head_pc_q   <= '0;
      tail_data_q <= '0;
      tail_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      out_pc_q    <= out_pc_d;
      req_en_q    <= req_en_d;
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_pc_q   <= head_pc_d;
      tail_data_q <= tail_data_d;
      tail_pc_q   <= tail_pc_d;
    end
  end

endmodule
`default_nettype wire
